mux_nx1_rr: RTL and testbench
=============================

# mux_nx1_rr

Parametrised N-input, W-bit registered stream multiplexer, the successor to the 2:1 vector mux. Every input channel and the output use a valid/ready handshake. Channel choice is either manual (`sel`) or fair round-robin (`mode`). It sits between multiple producers and a single consumer, and the registered output decouples the producers from the consumer's timing.

## Interface
Parameters:
- `N`, 4: number of input channels, 2..16.
- `W`, 8: data width per channel, ≥1.
- `SW`, `$clog2(N)`: select/channel-index width (derived, not overridden).

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mode`  in  1  0 = manual select via `sel`; 1 = round-robin.
- `sel`  in  SW  channel index used when `mode`=0.
- `in_data`  in  N*W  channel i at bits `[i*W +: W]`.
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; at most one bit high.
- `out_data`  out  W  registered output word.
- `out_ch`  out  SW  source channel of `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- `can_load` = `!out_valid | out_ready`.
- Grant selection, combinational:
  - Manual: the candidate is `sel`. A grant is issued iff `sel < N` and `in_valid[sel]`.
  - Round-robin: search channels `ptr+1, ptr+2, …` modulo N. The first channel with `in_valid` set is granted.
- `in_ready[g]` = `can_load` for the granted channel g. All other channels see 0. If no grant is issued, all bits are 0.
- Transfer on channel g happens when `in_valid[g] & in_ready[g]`. On the next edge:
  - `out_data` ← channel g data.
  - `out_ch` ← g.
  - `out_valid` ← 1.
  - In either mode, `ptr` ← g.
- The output drains when `out_valid & out_ready`. If no new load happens in the same cycle, `out_valid` ← 0.
- Load and drain in the same cycle is a back-to-back transfer. `out_valid` stays 1 and the data is replaced.
- While `out_valid & !out_ready`, `out_data` and `out_ch` hold stable. No input is accepted.
- `mode` or `sel` changes affect only the next grant. A held output word is never altered.
- `sel ≥ N` (N not a power of 2): no grant is issued and `in_ready` = 0.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - `ptr` = N-1, so the first round-robin search starts at channel 0.
  - Reset mid-stream discards the held word.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word/cycle while `out_ready` = 1.
- Combinational paths:
  - `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel` and `ptr`.
  - `in_ready` never depends on `in_data`.
  - There is no combinational path from any input to `out_*`.
- Handshake rules on each channel:
  - A producer must hold `in_valid` and `in_data` until it sees `in_ready`.
  - `in_valid` must not depend on `in_ready`.
- Round-robin fairness: with all N channels continuously valid and `out_ready` = 1, grants go 0,1,…,N-1,0,… with no channel skipped. Worst-case wait is N-1 transfers.

## Structure
- Package `mux_pkg` holds:
  - default constants `MUX_N_DEF` = 4 and `MUX_W_DEF` = 8;
  - the mode encodings `MODE_MANUAL` = 1'b0 and `MODE_RR` = 1'b1.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: `req[N-1:0]` and `ptr[SW-1:0]`;
  - outputs: one-hot `gnt[N-1:0]`, `gnt_idx`, `gnt_vld`;
  - it is purely combinational.
- The top level holds `ptr`, the output register, and the manual/RR grant multiplex.

## Test plan
1. Manual, N=4, W=8. `sel`=2, `in_valid`=4'b0100, ch2 data 8'hA5, `out_ready`=1.
   - Response: `in_ready`=4'b0100; next cycle `out_valid`=1, `out_data`=A5, `out_ch`=2.
   - With `sel`=1 and ch1 not valid: `in_ready`=0 and `out_valid` falls after the drain.
2. Round-robin, all four valid, data 10/11/12/13, `out_ready`=1 for 8 cycles.
   - Response: `out_ch` sequence 0,1,2,3,0,1,2,3 with matching data and no bubbles.
3. Backpressure: load ch0=55, hold `out_ready`=0 for 3 cycles while ch1 is valid.
   - Response: `out_data` stays 55 and `in_ready` = 0 throughout.
   - On `out_ready`=1: same-cycle reload, then `out_ch`=1.
4. Round-robin skip. After a grant to ch1, only ch0 and ch3 are valid.
   - Response: ch3 is granted before ch0.
5. Assert `rst_n`=0 asynchronously mid-cycle while `out_valid`=1.
   - Response: `out_valid`, `out_data` and `out_ch` go to 0 immediately.
   - After release with all channels valid in round-robin mode, the first grant is ch0.
6. N=3: `sel`=3 with all channels valid.
   - Response: `in_ready`=0 and no transfer.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the N:1 round-robin stream multiplexer
package mux_pkg;

    localparam int MUX_N_DEF = 4;
    localparam int MUX_W_DEF = 8;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr+1
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = MUX_N_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_vld
);

    // Walk ptr+1 .. ptr+N (mod N); the first requester wins, so the last
    // granted channel always has the lowest priority in the next search.
    always_comb begin
        int c;
        c       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!gnt_vld && req[c]) begin
                gnt[c]  = 1'b1;
                gnt_idx = SW'(c);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - N-input registered stream mux with manual or round-robin selection
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int N  = MUX_N_DEF,
    parameter  int W  = MUX_W_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic          can_load;
    logic          load;

    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          rr_vld;

    logic [N-1:0]  man_gnt;
    logic [N-1:0]  gnt_vec;
    logic [SW-1:0] gnt_idx;
    logic          gnt_vld;
    logic [W-1:0]  sel_data;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    assign can_load = !out_valid || out_ready;

    // Manual grant: one-hot of sel, only when sel names a real, valid channel.
    // Comparing against each index keeps sel >= N from ever matching.
    always_comb begin
        man_gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
                man_gnt[i] = 1'b1;
            end
        end
    end

    // Pick the active grant source; in_ready is gated only by output space.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (mode == MODE_RR) begin
            gnt_vec = rr_gnt;
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end else begin
            gnt_vec = man_gnt;
            gnt_idx = sel;
            gnt_vld = |man_gnt;
        end
        in_ready = can_load ? gnt_vec : '0;
        load     = gnt_vld && can_load;
    end

    // AND-OR data select driven by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_vec[i]) begin
                sel_data = sel_data | in_data[i*W +: W];
            end
        end
    end

    // Output register and fairness pointer; ptr tracks the last grant in both modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : mux_nx1_rr

// File: tb/tb_mux_nx1_rr.sv
// tb/tb_mux_nx1_rr.sv - scoreboard bench for the N:1 round-robin stream mux
module tb_mux_nx1_rr;

    logic        clk;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    mux_nx1_rr #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_nx1_rr #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d4(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        exp_q.push_back({8'(ch), d});
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = '0;
        drive_pt();
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_ch=%0d actual_data=%0h required=none", out_ch, out_data);
            end else begin
                e = exp_q.pop_front();
                chk("sb_ch", 32'(out_ch), 32'(e[15:8]));
                chk("sb_data", 32'(out_data), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        mode3     = 1'b0;
        sel3      = '0;
        in_data3  = '0;
        in_valid3 = '0;
        out_ready3 = 1'b0;

        // reset state
        drive_pt();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        drive_pt();
        rst_n = 1'b1;

        // 1: manual select
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        set_d4(8'h00, 8'h00, 8'hA5, 8'h00);
        push(2, 8'hA5);
        @(negedge clk);
        chk("man_in_ready", 32'(in_ready), 32'h4);
        drive_pt();
        sel = 2'd1;
        @(negedge clk);
        chk("man_invalid_sel_ready", 32'(in_ready), 0);
        drive_pt();
        @(negedge clk);
        chk("man_drain_valid", 32'(out_valid), 0);

        // 2: round-robin, all valid, no bubbles
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_d4(8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 8; i++) begin
            push(i % 4, 8'(8'h10 + (i % 4)));
            @(negedge clk);
            chk("rr_in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            if (i > 0) chk("rr_no_bubble", 32'(out_valid), 1);
            drive_pt();
        end
        in_valid = '0;
        drive_pt();

        // 3: backpressure then same-cycle reload
        in_valid = 4'b0001;
        set_d4(8'h55, 8'h66, 8'h00, 8'h00);
        push(0, 8'h55);
        @(negedge clk);
        chk("bp_first_ready", 32'(in_ready), 32'h1);
        drive_pt();
        in_valid = 4'b0010; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ready", 32'(in_ready), 0);
            chk("bp_hold_data", 32'(out_data), 32'h55);
            chk("bp_hold_valid", 32'(out_valid), 1);
            drive_pt();
        end
        out_ready = 1'b1;
        push(1, 8'h66);
        @(negedge clk);
        chk("bp_reload_ready", 32'(in_ready), 32'h2);
        drive_pt();
        in_valid = '0;
        @(negedge clk);
        chk("bp_reload_ch", 32'(out_ch), 1);
        drive_pt();

        // 4: round-robin skip after grant to ch1
        in_valid = 4'b1001;
        set_d4(8'h70, 8'h00, 8'h00, 8'h73);
        push(3, 8'h73);
        @(negedge clk);
        chk("skip_first_ready", 32'(in_ready), 32'h8);
        drive_pt();
        in_valid = 4'b0001;
        push(0, 8'h70);
        @(negedge clk);
        chk("skip_second_ready", 32'(in_ready), 32'h1);
        drive_pt();
        in_valid = '0;
        drive_pt();

        // 5: asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 4'b0100;
        set_d4(8'h00, 8'h00, 8'h22, 8'h00);
        drive_pt();
        in_valid = '0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_data", 32'(out_data), 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        chk("async_rst_ch", 32'(out_ch), 0);
        drive_pt();
        rst_n = 1'b1;
        set_d4(8'h10, 8'h11, 8'h12, 8'h13);
        in_valid = 4'b1111; out_ready = 1'b1;
        push(0, 8'h10);
        @(negedge clk);
        chk("post_rst_first_grant", 32'(in_ready), 32'h1);
        drive_pt();
        in_valid = '0;
        drive_pt();

        // 6: N=3 with out-of-range select
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h32, 8'h31, 8'h30};
        @(negedge clk);
        chk("n3_sel3_ready", 32'(in_ready3), 0);
        drive_pt();
        @(negedge clk);
        chk("n3_sel3_no_xfer", 32'(out_valid3), 0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(in_ready3), 32'h4);
        drive_pt();
        in_valid3 = '0;
        @(negedge clk);
        chk("n3_sel2_valid", 32'(out_valid3), 1);
        chk("n3_sel2_data", 32'(out_data3), 32'h32);
        chk("n3_sel2_ch", 32'(out_ch3), 2);
        drive_pt();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_nx1_rr
